// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I/Zicsr encodings, CSR addresses, cause codes and the ALU helper.
package rv32_pkg;
  typedef enum logic [6:0] {
    OP_LUI   = 7'h37,
    OP_AUIPC = 7'h17,
    OP_JAL   = 7'h6f,
    OP_JALR  = 7'h67,
    OP_BR    = 7'h63,
    OP_LD    = 7'h03,
    OP_ST    = 7'h23,
    OP_IMM   = 7'h13,
    OP_REG   = 7'h33,
    OP_FENCE = 7'h0f,
    OP_SYS   = 7'h73
  } opcode_e;
  localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4, F3_SR = 3'd5, F3_OR = 3'd6, F3_AND = 3'd7;
  localparam logic [6:0] F7_ALT = 7'h20;
  localparam logic [11:0] CSR_MSTATUS = 12'h300, CSR_MTVEC = 12'h305, CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342, CSR_TSELECT = 12'h7a0;
  localparam logic [31:0] CAUSE_BREAK = 32'd3, CAUSE_ECALL = 32'd11;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I_ECALL = 32'h0000_0073, I_EBREAK = 32'h0010_0073, I_MRET = 32'h3020_0073;
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      F3_ADD:  return alt ? a - b : a + b;
      F3_SLL:  return a << sh;
      F3_SLT:  return {31'b0, $signed(a) < $signed(b)};
      F3_SLTU: return {31'b0, a < b};
      F3_XOR:  return a ^ b;
      F3_SR:   return alt ? $unsigned($signed(a) >>> sh) : a >> sh;
      F3_OR:   return a | b;
      default: return a & b;
    endcase
  endfunction
endpackage

// File: rtl/core_memory.sv
// core_memory: unified word memory, combinational instruction and data reads, byte-enabled write.
module core_memory #(
  parameter int MEM_WORDS = 65536
) (
  input  logic        clk,
  input  logic [31:0] iaddr,
  output logic [31:0] idata,
  input  logic [31:0] daddr,
  output logic [31:0] rdata,
  input  logic [3:0]  be,
  input  logic [31:0] wdata
);
  localparam int AW = $clog2(MEM_WORDS);
  logic [31:0] m [0:MEM_WORDS-1];
  logic unused;
  assign unused = ^{iaddr[31:AW+2], iaddr[1:0], daddr[31:AW+2], daddr[1:0]};
  assign idata = m[iaddr[AW+1:2]];
  assign rdata = m[daddr[AW+1:2]];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (be[i]) m[daddr[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
endmodule

// File: rtl/core.sv
// core: RV32I 5-stage in-order pipeline (IF/ID/EX/MEM/WB) with Zicsr and M-mode traps.
module core import rv32_pkg::*; #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 65536
) (
  input logic clk,
  input logic rst
);
  logic [31:0] pc;
  logic [31:0] rs [0:31];
  logic [31:0] csr [0:4095];
  logic        d_v, e_v, m_we, m_ld, w_we;
  logic [31:0] d_pc, d_ir, e_pc, e_ir, e_a, e_b;
  logic [4:0]  m_rd, w_rd;
  logic [2:0]  m_f3;
  logic [3:0]  m_be;
  logic [31:0] m_res, m_addr, m_wd, w_res;
  logic [31:0] idata, m_rdata, lw_sh, m_out;
  opcode_e     opc, d_op;
  logic [2:0]  f3;
  logic [4:0]  rd, r1, r2, d_r1, d_r2;
  logic [11:0] ca;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, a, b, op2, res, tgt, npc, ls_addr;
  logic [31:0] cold, csrc, cnew, d_a, d_b, wd;
  logic [3:0]  be;
  logic        alt, bcond, take, ecall, ebreak, mret, redir, cwe, we, st, use1, use2, stall;
  core_memory #(.MEM_WORDS(MEM_WORDS)) memory (
    .clk(clk), .iaddr(pc), .idata(idata), .daddr(m_addr), .rdata(m_rdata), .be(m_be), .wdata(m_wd)
  );
  assign d_op = opcode_e'(d_ir[6:0]);
  assign d_r1 = d_ir[19:15];
  assign d_r2 = d_ir[24:20];
  assign d_a = w_we && w_rd == d_r1 ? w_res : rs[d_r1];
  assign d_b = w_we && w_rd == d_r2 ? w_res : rs[d_r2];
  assign use1 = !(d_op == OP_LUI || d_op == OP_AUIPC || d_op == OP_JAL);
  assign use2 = d_op == OP_REG || d_op == OP_BR || d_op == OP_ST;
  assign stall = e_v && opc == OP_LD && rd != 5'd0 && (use1 && rd == d_r1 || use2 && rd == d_r2);
  assign opc = opcode_e'(e_ir[6:0]);
  assign f3 = e_ir[14:12];
  assign rd = e_ir[11:7];
  assign r1 = e_ir[19:15];
  assign r2 = e_ir[24:20];
  assign ca = e_ir[31:20];
  assign imm_i = {{20{e_ir[31]}}, e_ir[31:20]};
  assign imm_s = {{20{e_ir[31]}}, e_ir[31:25], e_ir[11:7]};
  assign imm_b = {{19{e_ir[31]}}, e_ir[31], e_ir[7], e_ir[30:25], e_ir[11:8], 1'b0};
  assign imm_u = {e_ir[31:12], 12'b0};
  assign imm_j = {{11{e_ir[31]}}, e_ir[31], e_ir[19:12], e_ir[20], e_ir[30:21], 1'b0};
  // we is only ever set for rd != x0, so x0 can never be forwarded
  assign a = m_we && m_rd == r1 ? m_res : w_we && w_rd == r1 ? w_res : e_a;
  assign b = m_we && m_rd == r2 ? m_res : w_we && w_rd == r2 ? w_res : e_b;
  assign op2 = opc == OP_REG ? b : imm_i;
  assign alt = e_ir[31:25] == F7_ALT && (opc == OP_REG || f3 == F3_SR);
  assign cold = csr[ca];
  assign csrc = f3[2] ? {27'b0, r1} : a;
  assign cnew = f3[1:0] == 2'd1 ? csrc : f3[1:0] == 2'd2 ? cold | csrc : cold & ~csrc;
  assign cwe = e_v && opc == OP_SYS && f3[1:0] != 2'd0 && (f3[1:0] == 2'd1 || r1 != 5'd0);
  assign res = opc == OP_LUI ? imm_u : opc == OP_AUIPC ? e_pc + imm_u :
               opc == OP_JAL || opc == OP_JALR ? e_pc + 32'd4 : opc == OP_SYS ? cold : alu(f3, alt, a, op2);
  assign we = e_v && rd != 5'd0 && (opc inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_IMM, OP_REG} ||
              opc == OP_SYS && f3[1:0] != 2'd0);
  assign bcond = f3[2:1] == 2'd0 ? a == b : f3[2:1] == 2'd2 ? $signed(a) < $signed(b) : a < b;
  assign take = e_v && (opc == OP_JAL || opc == OP_JALR || opc == OP_BR && (bcond ^ f3[0]));
  assign tgt = opc == OP_JALR ? (a + imm_i) & ~32'd1 : e_pc + (opc == OP_JAL ? imm_j : imm_b);
  assign ecall = e_v && e_ir == I_ECALL;
  assign ebreak = e_v && e_ir == I_EBREAK;
  assign mret = e_v && e_ir == I_MRET;
  assign redir = take || ecall || ebreak || mret;
  assign npc = ecall || ebreak ? {csr[CSR_MTVEC][31:2], 2'b00} : mret ? csr[CSR_MEPC] : tgt;
  assign ls_addr = a + (opc == OP_ST ? imm_s : imm_i);
  assign st = e_v && opc == OP_ST;
  // misaligned stores produce no byte enables and are silently dropped
  assign be = !st ? 4'b0000 : f3[1:0] == 2'd0 ? 4'b0001 << ls_addr[1:0] :
              f3[1:0] == 2'd1 ? (ls_addr[0] ? 4'b0000 : 4'b0011 << ls_addr[1:0]) :
              ls_addr[1:0] != 2'd0 ? 4'b0000 : 4'b1111;
  assign wd = b << {ls_addr[1:0], 3'b000};
  assign lw_sh = m_rdata >> {m_addr[1:0], 3'b000};
  assign m_out = !m_ld ? m_res : m_f3[1:0] == 2'd0 ? {{24{~m_f3[2] & lw_sh[7]}}, lw_sh[7:0]} :
                 m_f3[1:0] == 2'd1 ? {{16{~m_f3[2] & lw_sh[15]}}, lw_sh[15:0]} : lw_sh;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc <= RESET_PC;
      d_v <= 1'b0;
      d_pc <= '0;
      d_ir <= NOP;
      e_v <= 1'b0;
      e_pc <= '0;
      e_ir <= NOP;
      e_a <= '0;
      e_b <= '0;
      m_we <= 1'b0;
      m_ld <= 1'b0;
      m_rd <= '0;
      m_f3 <= '0;
      m_be <= '0;
      m_res <= '0;
      m_addr <= '0;
      m_wd <= '0;
      w_we <= 1'b0;
      w_rd <= '0;
      w_res <= '0;
    end else begin
      pc <= redir ? npc : stall ? pc : pc + 32'd4;
      if (redir) begin
        d_v <= 1'b0;
        d_ir <= NOP;
      end else if (!stall) begin
        d_v <= 1'b1;
        d_pc <= pc;
        d_ir <= idata;
      end
      if (redir || stall) begin
        e_v <= 1'b0;
        e_ir <= NOP;
      end else begin
        e_v <= d_v;
        e_pc <= d_pc;
        e_ir <= d_ir;
        e_a <= d_a;
        e_b <= d_b;
      end
      m_we <= we;
      m_ld <= e_v && opc == OP_LD;
      m_rd <= rd;
      m_f3 <= f3;
      m_be <= be;
      m_res <= res;
      m_addr <= ls_addr;
      m_wd <= wd;
      w_we <= m_we;
      w_rd <= m_rd;
      w_res <= m_out;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < 32; i++) rs[i] <= '0;
    else if (w_we)
      rs[w_rd] <= w_res;
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < 4096; i++) csr[i] <= '0;
    else if (ecall || ebreak) begin
      csr[CSR_MEPC] <= e_pc;
      csr[CSR_MCAUSE] <= ecall ? CAUSE_ECALL : CAUSE_BREAK;
    end else if (cwe)
      csr[ca] <= cnew;
endmodule

// File: tb/tb_core.sv
// tb_core: directed programs for the core pipeline with hand-computed register, CSR and memory results.
module tb_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  localparam logic [31:0] NOPI = 32'h0000_0013;
  core dut (.clk(clk), .rst(rst));
  always #5 clk = ~clk;
  function automatic logic [31:0] ei(input logic [11:0] imm, input logic [4:0] r1, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {imm, r1, f3, rd, op};
  endfunction
  function automatic logic [31:0] er(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                     input logic [2:0] f3, input logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] es(input logic [11:0] imm, input logic [4:0] r2, input logic [4:0] r1,
                                     input logic [2:0] f3);
    return {imm[11:5], r2, r1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(input logic [12:0] imm, input logic [4:0] r2, input logic [4:0] r1,
                                     input logic [2:0] f3);
    return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] ej(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input int addr, input logic [31:0] v);
    dut.memory.m[addr >> 2] = v;
  endtask
  // reset, blank the low program area and install the shared trap handler at 0x100
  task automatic hold();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) wr(i * 4, NOPI);
    wr(32'h100, ei(12'h342, 0, 2, 8, 7'h73));
    wr(32'h104, ei(12'h341, 0, 2, 9, 7'h73));
    wr(32'h108, 32'h3020_0073);
  endtask
  task automatic go();
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic wait_pc(input string tag, input logic [31:0] t, input int budget);
    int n = 0;
    while (dut.pc !== t && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, dut.pc, t);
  endtask
  task automatic cycles_to(input string tag, input int r, input logic [31:0] v, input int exp_n);
    int n = 0;
    while (dut.rs[r] !== v && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, n, exp_n);
  endtask
  task automatic basic();
    hold();
    wr(32'h00, ei(1, 0, 0, 3, 7'h13));
    wr(32'h04, ej(21'h40, 0));
    wr(32'h44, ej(0, 0));
    go();
    wait_pc("basic_pc", 32'h44, 20);
    repeat (3) @(negedge clk);
    chk("basic_x3", dut.rs[3], 32'd1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pc", dut.pc, 32'h0);
    chk("rst_x1", dut.rs[1], 32'h0);
    chk("rst_mtvec", dut.csr[12'h305], 32'h0);
    basic();
    hold();
    wr(32'h200, 32'hDEAD_BEEF);
    wr(32'h00, ei(12'h200, 0, 2, 1, 7'h03));
    wr(32'h04, er(0, 1, 1, 0, 2));
    wr(32'h08, ej(0, 0));
    go();
    cycles_to("lu_cycles", 2, 32'hBD5B_7DDE, 7);
    chk("lu_x2", dut.rs[2], 32'hBD5B_7DDE);
    chk("lu_x1", dut.rs[1], 32'hDEAD_BEEF);
    hold();
    wr(32'h00, eb(13'd8, 0, 0, 0));
    wr(32'h04, ei(9, 0, 0, 5, 7'h13));
    wr(32'h08, ei(3, 0, 0, 6, 7'h13));
    wr(32'h0c, ej(0, 0));
    go();
    cycles_to("br_cycles", 6, 32'd3, 8);
    repeat (4) @(negedge clk);
    chk("br_skip_x5", dut.rs[5], 32'h0);
    hold();
    wr(32'h204, 32'h0);
    wr(32'h208, 32'h1122_3344);
    wr(32'h00, ei(5, 0, 0, 1, 7'h13));
    wr(32'h04, ei(3, 1, 0, 1, 7'h13));
    wr(32'h08, er(0, 1, 1, 0, 2));
    wr(32'h0c, er(7'h20, 2, 0, 0, 3));
    wr(32'h10, ei(12'h402, 3, 5, 4, 7'h13));
    wr(32'h14, ei(28, 3, 5, 5, 7'h13));
    wr(32'h18, er(0, 2, 3, 2, 6));
    wr(32'h1c, er(0, 2, 3, 3, 7));
    wr(32'h20, {20'h12345, 5'd8, 7'h37});
    wr(32'h24, {20'h00001, 5'd9, 7'h17});
    wr(32'h28, es(12'h204, 3, 0, 2));
    wr(32'h2c, es(12'h209, 1, 0, 0));
    wr(32'h30, ei(12'h204, 0, 0, 10, 7'h03));
    wr(32'h34, ei(12'h206, 0, 5, 11, 7'h03));
    wr(32'h38, ej(21'd8, 12));
    wr(32'h3c, ei(1, 0, 0, 13, 7'h13));
    wr(32'h40, ei(5, 0, 0, 0, 7'h13));
    wr(32'h44, er(0, 1, 0, 0, 14));
    wr(32'h48, er(0, 1, 1, 1, 15));
    wr(32'h4c, ei(12'hfff, 3, 4, 16, 7'h13));
    wr(32'h50, ej(0, 0));
    go();
    repeat (40) @(negedge clk);
    chk("alu_fwd_prio_x2", dut.rs[2], 32'd16);
    chk("alu_sub_x3", dut.rs[3], 32'hFFFF_FFF0);
    chk("alu_srai_x4", dut.rs[4], 32'hFFFF_FFFC);
    chk("alu_srli_x5", dut.rs[5], 32'h0000_000F);
    chk("alu_slt_x6", dut.rs[6], 32'd1);
    chk("alu_sltu_x7", dut.rs[7], 32'd0);
    chk("alu_lui_x8", dut.rs[8], 32'h1234_5000);
    chk("alu_auipc_x9", dut.rs[9], 32'h0000_1024);
    chk("mem_sw", dut.memory.m[32'h204 >> 2], 32'hFFFF_FFF0);
    chk("mem_sb", dut.memory.m[32'h208 >> 2], 32'h1122_0844);
    chk("ld_lb_x10", dut.rs[10], 32'hFFFF_FFF0);
    chk("ld_lhu_x11", dut.rs[11], 32'h0000_FFFF);
    chk("jal_link_x12", dut.rs[12], 32'h0000_003C);
    chk("jal_flush_x13", dut.rs[13], 32'h0);
    chk("x0_nofwd_x14", dut.rs[14], 32'd8);
    chk("alu_sll_x15", dut.rs[15], 32'h0000_0800);
    chk("alu_xori_x16", dut.rs[16], 32'h0000_000F);
    hold();
    wr(32'h00, ei(12'h100, 0, 0, 1, 7'h13));
    wr(32'h04, ei(12'h305, 1, 1, 0, 7'h73));
    wr(32'h08, ej(21'h18, 0));
    wr(32'h20, 32'h0000_0073);
    wr(32'h24, ei(1, 0, 0, 7, 7'h13));
    go();
    wait_pc("ecall_vec", 32'h100, 30);
    chk("ecall_mepc", dut.csr[12'h341], 32'h20);
    chk("ecall_mcause", dut.csr[12'h342], 32'd11);
    chk("ecall_mtvec", dut.csr[12'h305], 32'h100);
    wait_pc("mret_pc", 32'h20, 20);
    repeat (2) @(negedge clk);
    chk("ecall_h_x8", dut.rs[8], 32'd11);
    chk("ecall_h_x9", dut.rs[9], 32'h20);
    chk("ecall_flush_x7", dut.rs[7], 32'h0);
    hold();
    wr(32'h00, ei(12'h055, 0, 0, 1, 7'h13));
    wr(32'h04, ei(12'h7a0, 1, 1, 0, 7'h73));
    wr(32'h08, ei(12'h7a0, 0, 2, 10, 7'h73));
    wr(32'h0c, ei(12'h7a0, 5, 7, 11, 7'h73));
    wr(32'h10, ei(12'h100, 0, 0, 2, 7'h13));
    wr(32'h14, ei(12'h305, 2, 1, 0, 7'h73));
    wr(32'h18, ej(21'h18, 0));
    wr(32'h30, 32'h0010_0073);
    go();
    wait_pc("ebreak_vec", 32'h100, 40);
    chk("ebreak_mcause", dut.csr[12'h342], 32'd3);
    chk("ebreak_mepc", dut.csr[12'h341], 32'h30);
    chk("csrrci_tselect", dut.csr[12'h7a0], 32'h50);
    chk("csrr_x10", dut.rs[10], 32'h55);
    chk("csrrci_old_x11", dut.rs[11], 32'h55);
    wait_pc("ebreak_ret", 32'h30, 20);
    repeat (2) @(negedge clk);
    chk("ebreak_h_x8", dut.rs[8], 32'd3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_pc", dut.pc, 32'h0);
    chk("midrst_x10", dut.rs[10], 32'h0);
    chk("midrst_tselect", dut.csr[12'h7a0], 32'h0);
    chk("midrst_mem_keep", dut.memory.m[32'h204 >> 2], 32'hFFFF_FFF0);
    chk("midrst_mem_keep2", dut.memory.m[32'h200 >> 2], 32'hDEAD_BEEF);
    basic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
